parity_frame_receiver: RTL and testbench
========================================

Name: parity_frame_receiver

Overview:
Serial front end for the even-parity checking path. It receives an asynchronous 11-bit frame on a single line: start bit, 8 data bits sent LSB first, an even-parity bit, and a stop bit. It then presents the recovered byte and the received parity bit as a parallel word with a one-cycle valid strobe. The byte and parity bit feed the downstream even_parity_checker's data1 and parity_bit inputs. This block never checks parity itself.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 4.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter (derived, do not override).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  reset; asynchronous assert, active-low.
rx  input  1  serial line, asynchronous to clk, idle high.
data_out  output  8  last good frame's data byte; goes to data1 of the checker.
parity_out  output  1  last good frame's parity bit; goes to parity_bit of the checker.
frame_valid  output  1  one-cycle pulse; data_out/parity_out updated the same cycle.
framing_err  output  1  one-cycle pulse when the stop bit is sampled low.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, any time, including mid-frame): state=IDLE, data_out=8'h00, parity_out=0, frame_valid=0, framing_err=0, busy=0, counters=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer to give rx_s; all decisions use rx_s only.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1, sample rx_s:
  - 0 -> go to DATA with cnt=0 and bit_idx=0.
  - 1 -> treat as a glitch, go to IDLE, no strobe.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift bit bit_idx (LSB first) and reset cnt=0. After bit_idx==7 is sampled, go to PARITY.
- PARITY: at cnt==CLKS_PER_BIT-1, capture rx_s into the parity holding register, then go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1 -> register frame_valid=1 and load data_out/parity_out from the shift/hold registers, all on the same clock edge; go to IDLE.
  - 0 -> register framing_err=1, leave data_out/parity_out unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from being read as a new start bit.
- frame_valid and framing_err are never high in the same cycle and are never high for more than one cycle.
- data_out and parity_out hold their values between frames.
- Latency: frame_valid is high exactly 10*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 clocks after the first clk edge that samples rx low. For CLKS_PER_BIT=16 this is 171.
- Back-to-back frames: a new start bit may begin right after the stop bit. IDLE is re-entered about half a bit before the stop bit ends, so no frame is lost.
- busy is registered:
  - rises the cycle after IDLE leaves (IDLE->START);
  - falls the cycle IDLE is re-entered.

Test Plan:
1. Send byte 0xA5 with parity 0 and stop 1, CLKS_PER_BIT=16 -> frame_valid pulse exactly 171 clocks after the rx falling edge; data_out=0xA5, parity_out=0; downstream checker error=0.
2. Send byte 0x01 with parity 0 (wrong) -> frame_valid=1, data_out=0x01, parity_out=0 (the receiver does not reject it); checker error=1.
3. Drive rx low for 3 clocks, then high (glitch) -> START aborts at the mid-bit sample; no frame_valid or framing_err; busy falls within 12 clocks.
4. Send 0x3C with parity 0 and stop bit 0, keeping rx low for 40 more clocks -> single framing_err pulse; data_out keeps the previous value; state stays BREAK until rx rises; no start is detected while rx stays low.
5. Assert rst_n=0 halfway through the data bits of a frame, release it, then send a full 0x81 frame (parity 0) -> all outputs 0 during reset; no strobe from the aborted frame; the next frame gives data_out=0x81.
6. Send 0x00 (parity 0), 0xFF (parity 0) and 0x7F (parity 1) back-to-back with no idle gap -> three frame_valid pulses exactly 176 clocks apart, with correct data and parity in order.

Source files
------------

// File: rtl/parity_frame_receiver_if.sv
// Serial line and recovered-word outputs of parity_frame_receiver.
// The slave modport is the receiver; the master modport is the line driver / consumer.
interface parity_frame_receiver_if;
    logic       rx;
    logic [7:0] data_out;
    logic       parity_out;
    logic       frame_valid;
    logic       framing_err;
    logic       busy;

    modport master (
        output rx,
        input  data_out, parity_out, frame_valid, framing_err, busy
    );

    modport slave (
        input  rx,
        output data_out, parity_out, frame_valid, framing_err, busy
    );
endinterface

// File: rtl/parity_frame_receiver.sv
// Receives start + 8 data (LSB first) + parity + stop frames and presents the
// byte and raw parity bit as a parallel word; parity itself is not checked here.
module parity_frame_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic               clk,
    input logic               rst_n,
    parity_frame_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t           state, state_nx;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift, shift_nx;
    logic             par_hold, par_nx;
    logic [7:0]       data_q, data_nx;
    logic             parity_q, parity_nx;
    logic             fv_q, fv_nx;
    logic             fe_q, fe_nx;
    logic             busy_q;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_hold <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], bus.rx};
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_idx_nx;
            shift    <= shift_nx;
            par_hold <= par_nx;
            data_q   <= data_nx;
            parity_q <= parity_nx;
            fv_q     <= fv_nx;
            fe_q     <= fe_nx;
            busy_q   <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        par_nx     = par_hold;
        data_nx    = data_q;
        parity_nx  = parity_q;
        fv_nx      = 1'b0;
        fe_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cnt_nx   = '0;
                end
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_nx = '0;
                    // A start bit that is no longer low at mid-bit is line noise.
                    if (!rx_s) begin
                        state_nx   = DATA;
                        bit_idx_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = rx_s;
                    bit_idx_nx        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = PARITY;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (cnt == BIT_END) begin
                    cnt_nx   = '0;
                    par_nx   = rx_s;
                    state_nx = STOP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        fv_nx     = 1'b1;
                        data_nx   = shift;
                        parity_nx = par_hold;
                        state_nx  = IDLE;
                    end else begin
                        fe_nx    = 1'b1;
                        state_nx = BREAK;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line is not a start bit.
                if (rx_s) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.data_out    = data_q;
    assign bus.parity_out  = parity_q;
    assign bus.frame_valid = fv_q;
    assign bus.framing_err = fe_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver with a scoreboard of expected frames.
module tb_parity_frame_receiver;
    localparam int C = 16;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       e;
    } exp_t;

    logic clk;
    logic rst_n;
    parity_frame_receiver_if bus();

    parity_frame_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_fv  = 0;
    int   n_fe  = 0;
    int   t_fall = 0;
    int   fv_cyc[$];
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every frame_valid strobe.
    always @(negedge clk) begin
        if (bus.frame_valid || bus.framing_err)
            check("strobe_exclusive", {31'd0, bus.frame_valid & bus.framing_err}, 32'd0);
        if (bus.framing_err) n_fe++;
        if (bus.frame_valid) begin
            n_fv++;
            fv_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("data_out", {24'd0, bus.data_out}, {24'd0, x.d});
                check("parity_out", {31'd0, bus.parity_out}, {31'd0, x.p});
                check("checker_err", {31'd0, ^{bus.data_out, bus.parity_out}}, {31'd0, x.e});
            end
        end
    end

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0, fe0;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, bus.data_out}, 32'd0);
        check("rst_parity", {31'd0, bus.parity_out}, 32'd0);
        check("rst_fv", {31'd0, bus.frame_valid}, 32'd0);
        check("rst_fe", {31'd0, bus.framing_err}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: good frame, latency from rx falling edge
        sb.push_back('{d: 8'hA5, p: 1'b0, e: 1'b0});
        fv_cyc.delete();
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_fv_count", n_fv, 1);
        check("t1_latency", (fv_cyc.size() == 1) ? fv_cyc[0] - t_fall : -1, 171);

        // 2: wrong parity passes through unchanged
        sb.push_back('{d: 8'h01, p: 1'b0, e: 1'b1});
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t2_fv_count", n_fv, 2);

        // 3: short glitch aborts at mid-bit sample
        fv0 = n_fv; fe0 = n_fe;
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_busy_rise", {31'd0, bus.busy}, 32'd1);
        bus.rx = 1'b1;
        repeat (9) @(negedge clk);
        check("t3_busy_fall", {31'd0, bus.busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("t3_no_fv", n_fv, fv0);
        check("t3_no_fe", n_fe, fe0);

        // 4: low stop bit, line held low afterwards
        send_frame(8'h3C, 1'b0, 1'b0);
        bus.rx = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_fe_count", n_fe, fe0 + 1);
        check("t4_break_busy", {31'd0, bus.busy}, 32'd1);
        check("t4_data_hold", {24'd0, bus.data_out}, 32'h01);
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_idle_busy", {31'd0, bus.busy}, 32'd0);
        repeat (C * 2) @(negedge clk);
        check("t4_no_fv", n_fv, fv0);
        check("t4_fe_single", n_fe, fe0 + 1);

        // 5: reset mid-frame, then a clean frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_data", {24'd0, bus.data_out}, 32'd0);
        check("t5_rst_parity", {31'd0, bus.parity_out}, 32'd0);
        check("t5_rst_fv", {31'd0, bus.frame_valid}, 32'd0);
        check("t5_rst_fe", {31'd0, bus.framing_err}, 32'd0);
        check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        bus.rx = 1'b1;
        rst_n  = 1'b1;
        repeat (C * 12) @(negedge clk);
        check("t5_no_stale_fv", n_fv, fv0);
        sb.push_back('{d: 8'h81, p: 1'b0, e: 1'b0});
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t5_fv_count", n_fv, fv0 + 1);

        // 6: back-to-back frames
        fv_cyc.delete();
        sb.push_back('{d: 8'h00, p: 1'b0, e: 1'b0});
        sb.push_back('{d: 8'hFF, p: 1'b0, e: 1'b0});
        sb.push_back('{d: 8'h7F, p: 1'b1, e: 1'b0});
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h7F, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        check("t6_fv_count", fv_cyc.size(), 3);
        check("t6_gap01", (fv_cyc.size() == 3) ? fv_cyc[1] - fv_cyc[0] : -1, 176);
        check("t6_gap12", (fv_cyc.size() == 3) ? fv_cyc[2] - fv_cyc[1] : -1, 176);

        check("sb_empty", sb.size(), 0);
        check("fe_total", n_fe, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
